// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: bus widths, NOP word, FSM encodings.
// Optional prefetch support is selected with the INST_FETCH_PREFETCH_EN macro.
package inst_fetch_ctrl_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;
    localparam int unsigned CntW        = 4;

    localparam logic [InstBus-1:0] InstNop = 32'h0;

    typedef enum logic [1:0] {
        FETCH_IDLE     = 2'd0,
        FETCH_WAIT     = 2'd1,
        FETCH_PREFETCH = 2'd2
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_line_buf.sv
// Tag/data/valid storage for fetched words: entry0, plus a prefetch entry pf
// when INST_FETCH_PREFETCH_EN is defined. Lookup is combinational.
module fetch_line_buf
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = InstAddrBus,
    parameter int unsigned DATA_W = InstBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inv_i,
    input  logic              fill_i,
    input  logic [ADDR_W-1:0] fill_tag_i,
    input  logic [DATA_W-1:0] fill_data_i,
`ifdef INST_FETCH_PREFETCH_EN
    input  logic              fill_pf_i,
    input  logic              promote_i,
    output logic              hit_pf_o,
    output logic [ADDR_W-1:0] tag0_o,
    output logic [ADDR_W-1:0] tag_pf_o,
`endif
    input  logic [ADDR_W-1:0] lookup_i,
    output logic              hit0_o,
    output logic [DATA_W-1:0] data_o
);

    logic              e0_valid_q;
    logic [ADDR_W-1:0] e0_tag_q;
    logic [DATA_W-1:0] e0_data_q;

`ifdef INST_FETCH_PREFETCH_EN
    logic              pf_valid_q;
    logic [ADDR_W-1:0] pf_tag_q;
    logic [DATA_W-1:0] pf_data_q;

    // Entry0 is loaded by a demand fill or by promoting the prefetched word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e0_valid_q <= 1'b0;
            e0_tag_q   <= '0;
            e0_data_q  <= '0;
            pf_valid_q <= 1'b0;
            pf_tag_q   <= '0;
            pf_data_q  <= '0;
        end else if (inv_i) begin
            e0_valid_q <= 1'b0;
            pf_valid_q <= 1'b0;
        end else begin
            if (fill_i) begin
                e0_valid_q <= 1'b1;
                e0_tag_q   <= fill_tag_i;
                e0_data_q  <= fill_data_i;
            end else if (promote_i) begin
                e0_valid_q <= pf_valid_q;
                e0_tag_q   <= pf_tag_q;
                e0_data_q  <= pf_data_q;
            end
            if (fill_pf_i) begin
                pf_valid_q <= 1'b1;
                pf_tag_q   <= fill_tag_i;
                pf_data_q  <= fill_data_i;
            end else if (promote_i) begin
                pf_valid_q <= 1'b0;
            end
        end
    end

    assign hit0_o   = e0_valid_q && (e0_tag_q == lookup_i);
    assign hit_pf_o = pf_valid_q && (pf_tag_q == lookup_i);
    assign data_o   = hit_pf_o ? pf_data_q : e0_data_q;
    assign tag0_o   = e0_tag_q;
    assign tag_pf_o = pf_tag_q;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e0_valid_q <= 1'b0;
            e0_tag_q   <= '0;
            e0_data_q  <= '0;
        end else if (inv_i) begin
            e0_valid_q <= 1'b0;
        end else if (fill_i) begin
            e0_valid_q <= 1'b1;
            e0_tag_q   <= fill_tag_i;
            e0_data_q  <= fill_data_i;
        end
    end

    assign hit0_o = e0_valid_q && (e0_tag_q == lookup_i);
    assign data_o = e0_data_q;
`endif

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: stretches the core's single-cycle fetch into a MEM_LAT-cycle
// memory read with a one-word buffer. INST_FETCH_PREFETCH_EN adds next-word prefetch.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = InstAddrBus,
    parameter int unsigned DATA_W  = InstBus,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic              cpu_flush_i,
    output logic [DATA_W-1:0] cpu_inst_o,
    output logic              cpu_stall_o,
    output logic              misalign_o,
    output logic              mem_ce_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    fetch_state_e      state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              mem_ce_q, mem_ce_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic              aligned_c;
    logic              access_c;
    logic              buf_hit0;
    logic [DATA_W-1:0] buf_data;
    logic              buf_fill;
    logic              buf_inv;
    logic              stall_c;
    logic [DATA_W-1:0] inst_c;

`ifdef INST_FETCH_PREFETCH_EN
    logic              arm_q, arm_d;
    logic              buf_hit_pf;
    logic              buf_fill_pf;
    logic              buf_promote;
    logic [ADDR_W-1:0] buf_tag0;
    logic [ADDR_W-1:0] buf_tag_pf;
`endif

    assign aligned_c = is_word_aligned(cpu_addr_i[1:0]);
    assign access_c  = cpu_ce_i && aligned_c;

    fetch_line_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_line_buf (
        .clk         (clk),
        .rst         (rst),
        .inv_i       (buf_inv),
        .fill_i      (buf_fill),
        .fill_tag_i  (mem_addr_q),
        .fill_data_i (mem_data_i),
`ifdef INST_FETCH_PREFETCH_EN
        .fill_pf_i   (buf_fill_pf),
        .promote_i   (buf_promote),
        .hit_pf_o    (buf_hit_pf),
        .tag0_o      (buf_tag0),
        .tag_pf_o    (buf_tag_pf),
`endif
        .lookup_i    (cpu_addr_i),
        .hit0_o      (buf_hit0),
        .data_o      (buf_data)
    );

    // Next-state, memory request and core-facing combinational outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_ce_d   = mem_ce_q;
        mem_addr_d = mem_addr_q;
        buf_fill   = 1'b0;
        buf_inv    = 1'b0;
        stall_c    = 1'b0;
        inst_c     = InstNop;
`ifdef INST_FETCH_PREFETCH_EN
        arm_d       = arm_q;
        buf_fill_pf = 1'b0;
        buf_promote = 1'b0;
`endif
        if (cpu_flush_i) begin
            state_d  = FETCH_IDLE;
            mem_ce_d = 1'b0;
            buf_inv  = 1'b1;
`ifdef INST_FETCH_PREFETCH_EN
            arm_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                FETCH_IDLE: begin
                    if (access_c && buf_hit0) begin
                        inst_c = buf_data;
`ifdef INST_FETCH_PREFETCH_EN
                        if (arm_q) begin
                            mem_addr_d = buf_tag0 + ADDR_W'(4);
                            mem_ce_d   = 1'b1;
                            cnt_d      = CntW'(MEM_LAT - 1);
                            state_d    = FETCH_PREFETCH;
                            arm_d      = 1'b0;
                        end
                    end else if (access_c && buf_hit_pf) begin
                        // Promote the prefetched word and immediately fetch the one after it.
                        inst_c      = buf_data;
                        buf_promote = 1'b1;
                        mem_addr_d  = buf_tag_pf + ADDR_W'(4);
                        mem_ce_d    = 1'b1;
                        cnt_d       = CntW'(MEM_LAT - 1);
                        state_d     = FETCH_PREFETCH;
`endif
                    end else if (access_c) begin
                        stall_c    = 1'b1;
                        mem_addr_d = cpu_addr_i;
                        mem_ce_d   = 1'b1;
                        cnt_d      = CntW'(MEM_LAT - 1);
                        state_d    = FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    stall_c = 1'b1;
                    if (cnt_q == '0) begin
                        buf_fill = 1'b1;
                        mem_ce_d = 1'b0;
                        state_d  = FETCH_IDLE;
`ifdef INST_FETCH_PREFETCH_EN
                        arm_d    = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
`ifdef INST_FETCH_PREFETCH_EN
                FETCH_PREFETCH: begin
                    // Entry0 hits are served; any demand miss waits for the prefetch to drain.
                    if (access_c && buf_hit0) begin
                        inst_c = buf_data;
                    end else if (access_c) begin
                        stall_c = 1'b1;
                    end
                    if (cnt_q == '0) begin
                        buf_fill_pf = 1'b1;
                        mem_ce_d    = 1'b0;
                        state_d     = FETCH_IDLE;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
`endif
                default: begin
                    state_d  = FETCH_IDLE;
                    mem_ce_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH_IDLE;
            cnt_q      <= '0;
            mem_ce_q   <= 1'b0;
            mem_addr_q <= '0;
`ifdef INST_FETCH_PREFETCH_EN
            arm_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_ce_q   <= mem_ce_d;
            mem_addr_q <= mem_addr_d;
`ifdef INST_FETCH_PREFETCH_EN
            arm_q      <= arm_d;
`endif
        end
    end

    // Combinational outputs are held at their reset values while rst is asserted.
    assign cpu_stall_o = rst && stall_c;
    assign cpu_inst_o  = rst ? inst_c : InstNop;
    assign misalign_o  = rst && cpu_ce_i && !aligned_c;
    assign mem_ce_o    = mem_ce_q;
    assign mem_addr_o  = mem_addr_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl (MEM_LAT=2); prefetch checks follow INST_FETCH_PREFETCH_EN.
module tb_inst_fetch_ctrl;

`ifdef INST_FETCH_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic        cpu_flush_i;
    logic [31:0] cpu_inst_o;
    logic        cpu_stall_o;
    logic        misalign_o;
    logic        mem_ce_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;

    int n_assert = 0;
    int n_fail   = 0;

    inst_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_ce_i    (cpu_ce_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_flush_i (cpu_flush_i),
        .cpu_inst_o  (cpu_inst_o),
        .cpu_stall_o (cpu_stall_o),
        .misalign_o  (misalign_o),
        .mem_ce_o    (mem_ce_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_i  (mem_data_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h3C01_0001 : (32'h1000_0000 | a);
    endfunction

    always_comb mem_data_i = mem_ce_o ? mem_word(mem_addr_o) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One fetch cycle: drive just after the edge, leave the caller to sample mid-cycle.
    task automatic cyc(input logic ce, input logic [31:0] addr, input logic flush);
        @(posedge clk);
        #1;
        cpu_ce_i    = ce;
        cpu_addr_i  = addr;
        cpu_flush_i = flush;
        #3;
    endtask

    initial begin
        rst = 1'b0; cpu_ce_i = 1'b0; cpu_addr_i = '0; cpu_flush_i = 1'b0;
        #2;
        chk("rst_inst", cpu_inst_o, 32'h0);
        chk("rst_stall", 32'(cpu_stall_o), 32'h0);
        chk("rst_misalign", 32'(misalign_o), 32'h0);
        chk("rst_mem_ce", 32'(mem_ce_o), 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // 1: cold miss on 0x0, three stall cycles then the word
        cyc(1'b1, 32'h0, 1'b0);
        chk("t1_stall0", 32'(cpu_stall_o), 32'h1);
        chk("t1_ce0", 32'(mem_ce_o), 32'h0);
        cyc(1'b1, 32'h0, 1'b0);
        chk("t1_stall1", 32'(cpu_stall_o), 32'h1);
        chk("t1_ce1", 32'(mem_ce_o), 32'h1);
        chk("t1_inst1", cpu_inst_o, 32'h0);
        cyc(1'b1, 32'h0, 1'b0);
        chk("t1_stall2", 32'(cpu_stall_o), 32'h1);
        cyc(1'b1, 32'h0, 1'b0);
        chk("t1_stall3", 32'(cpu_stall_o), 32'h0);
        chk("t1_inst3", cpu_inst_o, 32'h3C01_0001);
        chk("t1_ce3", 32'(mem_ce_o), 32'h0);

        // 2: repeated fetch served from the buffer
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 32'h0, 1'b0);
            chk("t2_stall", 32'(cpu_stall_o), 32'h0);
            chk("t2_inst", cpu_inst_o, 32'h3C01_0001);
            chk("t2_mem_ce", 32'(mem_ce_o), 32'((PF && k < 2) ? 1 : 0));
        end
        chk("t2_misalign", 32'(misalign_o), 32'h0);

        // 3: flush during the second WAIT cycle, then refetch misses again
        cyc(1'b1, 32'h8, 1'b0);
        chk("t3_stall_miss", 32'(cpu_stall_o), 32'h1);
        cyc(1'b1, 32'h8, 1'b0);
        chk("t3_mem_addr", mem_addr_o, 32'h8);
        cyc(1'b1, 32'h8, 1'b1);
        chk("t3_stall_flush", 32'(cpu_stall_o), 32'h0);
        cyc(1'b1, 32'h8, 1'b0);
        chk("t3_ce_after_flush", 32'(mem_ce_o), 32'h0);
        chk("t3_refetch_stall0", 32'(cpu_stall_o), 32'h1);
        cyc(1'b1, 32'h8, 1'b0);
        chk("t3_refetch_stall1", 32'(cpu_stall_o), 32'h1);
        cyc(1'b1, 32'h8, 1'b0);
        chk("t3_refetch_stall2", 32'(cpu_stall_o), 32'h1);
        cyc(1'b1, 32'h8, 1'b0);
        chk("t3_refetch_stall3", 32'(cpu_stall_o), 32'h0);
        chk("t3_refetch_inst", cpu_inst_o, 32'h1000_0008);

        // ce low on a buffered address yields NOP without stall
        cyc(1'b0, 32'h8, 1'b0);
        chk("ce0_inst", cpu_inst_o, 32'h0);
        chk("ce0_stall", 32'(cpu_stall_o), 32'h0);
        repeat (2) cyc(1'b0, 32'h8, 1'b0);

        // 4: misaligned fetch
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 32'h6, 1'b0);
            chk("t4_misalign", 32'(misalign_o), 32'h1);
            chk("t4_inst", cpu_inst_o, 32'h0);
            chk("t4_stall", 32'(cpu_stall_o), 32'h0);
            chk("t4_mem_ce", 32'(mem_ce_o), 32'h0);
        end

        // 5: reset asserted during WAIT
        cyc(1'b1, 32'h20, 1'b0);
        cyc(1'b1, 32'h20, 1'b0);
        chk("t5_ce_wait", 32'(mem_ce_o), 32'h1);
        rst = 1'b0;
        #1;
        chk("t5_rst_ce", 32'(mem_ce_o), 32'h0);
        chk("t5_rst_addr", mem_addr_o, 32'h0);
        chk("t5_rst_stall", 32'(cpu_stall_o), 32'h0);
        chk("t5_rst_inst", cpu_inst_o, 32'h0);
        cpu_ce_i = 1'b0;
        @(negedge clk) rst = 1'b1;
        cyc(1'b1, 32'h8, 1'b0);
        chk("t5_miss_after_rst", 32'(cpu_stall_o), 32'h1);
        cyc(1'b1, 32'h8, 1'b0);
        cyc(1'b1, 32'h8, 1'b0);
        cyc(1'b1, 32'h8, 1'b0);
        chk("t5_inst", cpu_inst_o, 32'h1000_0008);
        repeat (3) cyc(1'b0, 32'h8, 1'b0);

        // 6: sequential fetch 0x10 then 0x14
        cyc(1'b1, 32'h10, 1'b0);
        chk("t6_miss10", 32'(cpu_stall_o), 32'h1);
        cyc(1'b1, 32'h10, 1'b0);
        cyc(1'b1, 32'h10, 1'b0);
        cyc(1'b1, 32'h10, 1'b0);
        chk("t6_inst10", cpu_inst_o, 32'h1000_0010);
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 32'h10, 1'b0);
            chk("t6_hold10", 32'(cpu_stall_o), 32'h0);
        end
        cyc(1'b1, 32'h14, 1'b0);
        if (PF) begin
            chk("t6_pf_stall14", 32'(cpu_stall_o), 32'h0);
            chk("t6_pf_inst14", cpu_inst_o, 32'h1000_0014);
            cyc(1'b1, 32'h14, 1'b0);
            chk("t6_pf_next_ce", 32'(mem_ce_o), 32'h1);
            chk("t6_pf_next_addr", mem_addr_o, 32'h18);
        end else begin
            chk("t6_stall14", 32'(cpu_stall_o), 32'h1);
            cyc(1'b1, 32'h14, 1'b0);
            chk("t6_addr14", mem_addr_o, 32'h14);
            cyc(1'b1, 32'h14, 1'b0);
            cyc(1'b1, 32'h14, 1'b0);
            chk("t6_inst14", cpu_inst_o, 32'h1000_0014);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
